// File: rtl/invader_hit_detect.sv
// Per-frame bullet vs. invader-grid collision test, producing the encoded hit index.
// Latency: frame in cycle N -> REPORT in cycle N+5+col+row (worst case N+19); misses return to IDLE early.
// Backpressure: none; a frame pulse arriving while busy is dropped and the in-flight check runs to completion.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   frame                one-cycle pulse that starts a check (if bullet_active and idle)
//   bullet_active        player bullet in flight
//   bullet_x/bullet_y    bullet tip position, pixels
//   invaders             alive bitmap, bit idx = row*COLS+col (row 0 top, col 0 left)
//   invaders_x/y         grid origin (top-left of invader 0)
//   invader_collision    idx+1 of the hit invader for exactly one cycle, else 0
//   bullet_hit           one-cycle pulse coincident with a nonzero invader_collision
//   busy                 high whenever the checker is not idle
//
// The default geometry (11x5 grid) sets the fixed widths: col 4 bits, row 3 bits, index 6 bits.
module invader_hit_detect #(
  parameter int COLS    = 11,
  parameter int ROWS    = 5,
  parameter int PITCH_X = 24,
  parameter int PITCH_Y = 24,
  parameter int INV_W   = 16,
  parameter int INV_H   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame,
  input  logic                 bullet_active,
  input  logic [9:0]           bullet_x,
  input  logic [9:0]           bullet_y,
  input  logic [COLS*ROWS-1:0] invaders,
  input  logic [9:0]           invaders_x,
  input  logic [9:0]           invaders_y,
  output logic [5:0]           invader_collision,
  output logic                 bullet_hit,
  output logic                 busy
);

  // Geometry constants sized to the 11-bit datapath so every compare is width-matched.
  localparam logic [10:0] SPAN_X = 11'(COLS * PITCH_X);
  localparam logic [10:0] SPAN_Y = 11'(ROWS * PITCH_Y);
  localparam logic [10:0] PX     = 11'(PITCH_X);
  localparam logic [10:0] PY     = 11'(PITCH_Y);
  localparam logic [10:0] IW     = 11'(INV_W);
  localparam logic [10:0] IH     = 11'(INV_H);
  localparam logic [5:0]  COLS6  = 6'(COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNDS,
    S_DIV_X,
    S_DIV_Y,
    S_LOOKUP,
    S_REPORT
  } state_t;

  state_t state_q, state_d;

  // Snapshot of the frame inputs; the check runs only on these.
  logic [9:0]           bx_q, bx_d;
  logic [9:0]           by_q, by_d;
  logic [9:0]           ix_q, ix_d;
  logic [9:0]           iy_q, iy_d;
  logic [COLS*ROWS-1:0] inv_q, inv_d;

  // Iterative division state: remainder within the cell and cell coordinate.
  logic [10:0] rem_x_q, rem_x_d;
  logic [10:0] rem_y_q, rem_y_d;
  logic [3:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;

  // Registered outputs.
  logic [5:0] coll_q, coll_d;
  logic       hit_q, hit_d;

  // Offsets from the grid origin; zero-extended so bit 10 is the borrow (negative).
  logic [10:0] dx, dy;
  logic [5:0]  idx;

  assign dx  = {1'b0, bx_q} - {1'b0, ix_q};
  assign dy  = {1'b0, by_q} - {1'b0, iy_q};
  assign idx = 6'(row_q) * COLS6 + 6'(col_q);

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    ix_d    = ix_q;
    iy_d    = iy_q;
    inv_d   = inv_q;
    rem_x_d = rem_x_q;
    rem_y_d = rem_y_q;
    col_d   = col_q;
    row_d   = row_q;
    coll_d  = 6'd0;
    hit_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame && bullet_active) begin
          bx_d    = bullet_x;
          by_d    = bullet_y;
          ix_d    = invaders_x;
          iy_d    = invaders_y;
          inv_d   = invaders;
          col_d   = 4'd0;
          row_d   = 3'd0;
          state_d = S_BOUNDS;
        end
      end

      S_BOUNDS: begin
        // Outside the grid rectangle: no cell can contain the bullet.
        if (dx[10] || dy[10] || (dx >= SPAN_X) || (dy >= SPAN_Y)) begin
          state_d = S_IDLE;
        end else begin
          rem_x_d = dx;
          rem_y_d = dy;
          state_d = S_DIV_X;
        end
      end

      S_DIV_X: begin
        if (rem_x_q >= PX) begin
          rem_x_d = rem_x_q - PX;
          col_d   = col_q + 4'd1;
        end else begin
          state_d = S_DIV_Y;
        end
      end

      S_DIV_Y: begin
        if (rem_y_q >= PY) begin
          rem_y_d = rem_y_q - PY;
          row_d   = row_q + 3'd1;
        end else begin
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        // Remainders beyond the sprite size fall in the gap between invaders.
        if ((rem_x_q < IW) && (rem_y_q < IH) && inv_q[idx]) begin
          coll_d  = idx + 6'd1;
          hit_d   = 1'b1;
          state_d = S_REPORT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      ix_q    <= '0;
      iy_q    <= '0;
      inv_q   <= '0;
      rem_x_q <= '0;
      rem_y_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      coll_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      ix_q    <= ix_d;
      iy_q    <= iy_d;
      inv_q   <= inv_d;
      rem_x_q <= rem_x_d;
      rem_y_q <= rem_y_d;
      col_q   <= col_d;
      row_q   <= row_d;
      coll_q  <= coll_d;
      hit_q   <= hit_d;
    end
  end

  // Output registers load only on the LOOKUP->REPORT transition, so they are
  // nonzero exactly during the REPORT cycle.
  assign invader_collision = coll_q;
  assign bullet_hit        = hit_q;
  assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_invader_hit_detect.sv
// Scoreboard bench for invader_hit_detect: expected reports are queued when a frame is driven
// and popped when the DUT pulses; latency is checked against the cycle the frame was driven.
module tb_invader_hit_detect;

  localparam int GX = 100;
  localparam int GY = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0;
  logic        bullet_active = 1'b0;
  logic [9:0]  bullet_x = '0;
  logic [9:0]  bullet_y = '0;
  logic [54:0] invaders = '0;
  logic [9:0]  invaders_x = 10'(GX);
  logic [9:0]  invaders_y = 10'(GY);
  logic [5:0]  invader_collision;
  logic        bullet_hit;
  logic        busy;

  invader_hit_detect dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame             (frame),
    .bullet_active     (bullet_active),
    .bullet_x          (bullet_x),
    .bullet_y          (bullet_y),
    .invaders          (invaders),
    .invaders_x        (invaders_x),
    .invaders_y        (invaders_y),
    .invader_collision (invader_collision),
    .bullet_hit        (bullet_hit),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx1;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference model: plain division/modulo on the grid geometry.
  task automatic model_push(input int bx, input int by, input logic [54:0] inv, input int n);
    int dx, dy, col, row, rx, ry;
    exp_t e;
    dx = bx - GX;
    dy = by - GY;
    if (dx < 0 || dy < 0 || dx >= 11 * 24 || dy >= 5 * 24) return;
    col = dx / 24;
    rx  = dx % 24;
    row = dy / 24;
    ry  = dy % 24;
    if (rx < 16 && ry < 16 && inv[row * 11 + col]) begin
      e.idx1 = row * 11 + col + 1;
      e.cyc  = n + 5 + col + row;
      sb.push_back(e);
    end
  endtask

  // Drive one frame pulse (cycle N = cyc while frame is high); queue the expectation.
  task automatic start_frame(input int bx, input int by, input logic act, input logic [54:0] inv);
    @(negedge clk);
    bullet_x      = 10'(bx);
    bullet_y      = 10'(by);
    bullet_active = act;
    invaders      = inv;
    frame         = 1'b1;
    if (act) model_push(bx, by, inv, cyc);
    @(negedge clk);
    frame = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({tag, "_idle"}, busy, 0);
    repeat (2) @(negedge clk);
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  task automatic run(input string tag, input int bx, input int by, input logic act,
                     input logic [54:0] inv);
    start_frame(bx, by, act, inv);
    wait_idle(tag);
  endtask

  // Output monitor: any pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (invader_collision != 0 || bullet_hit)) begin
      if (sb.size() == 0) begin
        chk("unexpected_report", invader_collision, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("collision_idx", invader_collision, e.idx1);
        chk("report_cycle", cyc, e.cyc);
        chk("bullet_hit", bullet_hit, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 20000", cyc);
    $fatal(1, "watchdog");
  end

  logic [54:0] all_alive;
  logic [54:0] dead0;

  initial begin
    all_alive = '1;
    dead0     = all_alive;
    dead0[0]  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_collision", invader_collision, 0);
    chk("rst_hit", bullet_hit, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Hits: top-left, bottom-right, interior cell, sprite-edge pixel.
    run("top_left", 100, 50, 1'b1, all_alive);
    run("bottom_right", 345, 149, 1'b1, all_alive);
    run("interior", 177, 108, 1'b1, all_alive);
    run("sprite_edge", 115, 65, 1'b1, all_alive);

    // Misses: gap, left of grid, dead invader, just past sprite, right edge of grid.
    run("gap", 120, 50, 1'b1, all_alive);
    run("left", 99, 60, 1'b1, all_alive);
    run("dead", 100, 50, 1'b1, dead0);
    run("past_sprite", 116, 50, 1'b1, all_alive);
    run("beyond_grid", 364, 50, 1'b1, all_alive);
    run("below_grid", 100, 170, 1'b1, all_alive);

    // Inactive bullet: nothing starts.
    start_frame(100, 50, 1'b0, all_alive);
    for (int i = 0; i < 3; i++) begin
      chk("inactive_busy", busy, 0);
      chk("inactive_coll", invader_collision, 0);
      @(negedge clk);
    end

    // Frame while busy and input change mid-check are both ignored.
    start_frame(345, 149, 1'b1, all_alive);
    repeat (2) @(negedge clk);
    chk("busy_mid", busy, 1);
    frame    = 1'b1;
    bullet_x = 10'd100;
    bullet_y = 10'd50;
    invaders = '0;
    @(negedge clk);
    frame = 1'b0;
    wait_idle("busy_ignore");

    // Reset during DIV_Y (cycles N+13..N+17 for col 10, row 4).
    start_frame(345, 149, 1'b1, all_alive);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_coll", invader_collision, 0);
    chk("midrst_hit", bullet_hit, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("postrst_busy", busy, 0);
    run("after_reset", 100, 50, 1'b1, all_alive);
    run("after_reset2", 178, 82, 1'b1, all_alive);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
